// File: rtl/matrix_engine_pkg.sv
// Shared types and helpers for the matrix-engine address generators.
package matrix_engine_pkg;

  localparam int unsigned SEQ_WIDTH  = 8;
  localparam int unsigned SEQ_LOOP_W = 4;
  localparam int unsigned SEQ_MAX_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Zero-extended add; bit SEQ_MAX_W (and any bit above the caller's width)
  // carries the overflow out of the caller's narrower operands.
  function automatic logic [SEQ_MAX_W:0] sum_with_carry(
    input logic [SEQ_MAX_W-1:0] a,
    input logic [SEQ_MAX_W-1:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/seq_stride_adder.sv
// Stride adder: next = addr + step, with overflow set when the sum carries
// out of WIDTH bits or lands beyond limit.
module seq_stride_adder
  import matrix_engine_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH
) (
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] next,
  output logic             overflow
);

  logic [SEQ_MAX_W:0] sum;

  // Widened add and window compare.
  always_comb begin
    sum      = sum_with_carry(SEQ_MAX_W'(addr), SEQ_MAX_W'(step));
    next     = sum[WIDTH-1:0];
    overflow = (|sum[SEQ_MAX_W:WIDTH]) || (sum[WIDTH-1:0] > limit);
  end

endmodule

// File: rtl/instr_addr_sequencer.sv
// Instruction-address sequencer: walks [base, limit] in strides of step and
// offers each address over a valid/ready handshake.
// Optional macro SEQ_LOOP_EN: adds repeat_cnt and repeats the pass
// repeat_cnt+1 times, pulsing wrapped at each restart.
module instr_addr_sequencer
  import matrix_engine_pkg::*;
#(
  parameter int unsigned WIDTH  = SEQ_WIDTH,
  parameter int unsigned LOOP_W = SEQ_LOOP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  base,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  step,
  input  logic              jump_valid,
  input  logic [WIDTH-1:0]  jump_addr,
`ifdef SEQ_LOOP_EN
  input  logic [LOOP_W-1:0] repeat_cnt,
`endif
  output logic [WIDTH-1:0]  addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  output logic              err
);

  seq_state_t        state;
  logic [WIDTH-1:0]  base_r;
  logic [WIDTH-1:0]  limit_r;
  logic [WIDTH-1:0]  step_r;
  logic [LOOP_W-1:0] loop_cnt;
  logic [LOOP_W-1:0] rep_in;
  logic [WIDTH-1:0]  next_addr;
  logic              end_of_pass;
  logic              jump_in_win;

  // Without the loop feature the repeat count is held at zero, so the
  // wrap branch below is never taken and wrapped stays low.
`ifdef SEQ_LOOP_EN
  assign rep_in = repeat_cnt;
`else
  assign rep_in = '0;
`endif

  seq_stride_adder #(.WIDTH(WIDTH)) u_adder (
    .addr     (addr_out),
    .step     (step_r),
    .limit    (limit_r),
    .next     (next_addr),
    .overflow (end_of_pass)
  );

  // Jump target must lie inside the captured window.
  always_comb begin
    jump_in_win = (jump_addr >= base_r) && (jump_addr <= limit_r);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      base_r     <= '0;
      limit_r    <= '0;
      step_r     <= '0;
      loop_cnt   <= '0;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrapped    <= 1'b0;
      err        <= 1'b0;
    end else begin
      done    <= 1'b0;
      wrapped <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (base <= limit) begin
              base_r     <= base;
              limit_r    <= limit;
              step_r     <= (step == '0) ? WIDTH'(1) : step;
              loop_cnt   <= rep_in;
              addr_out   <= base;
              err        <= 1'b0;
              addr_valid <= 1'b1;
              busy       <= 1'b1;
              state      <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          // An in-window jump overrides both increment and end-of-pass.
          if (jump_valid && jump_in_win) begin
            addr_out <= jump_addr;
          end else begin
            if (jump_valid) err <= 1'b1;
            if (addr_ready) begin
              if (!end_of_pass) begin
                addr_out <= next_addr;
              end else if (loop_cnt != '0) begin
                addr_out <= base_r;
                loop_cnt <= loop_cnt - LOOP_W'(1);
                wrapped  <= 1'b1;
              end else begin
                addr_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                state      <= DONE;
              end
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_addr_sequencer.sv
// Self-checking bench for instr_addr_sequencer.
module tb_instr_addr_sequencer;

  localparam int W = 8;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] base = '0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] step = '0;
  logic         jump_valid = 1'b0;
  logic [W-1:0] jump_addr = '0;
  logic [L-1:0] repeat_cnt = '0;
  logic [W-1:0] addr_out;
  logic         addr_valid;
  logic         addr_ready = 1'b0;
  logic         busy;
  logic         done;
  logic         wrapped;
  logic         err;

  instr_addr_sequencer #(.WIDTH(W), .LOOP_W(L)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base       (base),
    .limit      (limit),
    .step       (step),
    .jump_valid (jump_valid),
    .jump_addr  (jump_addr),
`ifdef SEQ_LOOP_EN
    .repeat_cnt (repeat_cnt),
`endif
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .busy       (busy),
    .done       (done),
    .wrapped    (wrapped),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model state: captured window, remaining addresses of the
  // current pass, passes still to run, sticky error.
  int mb, ml, ms, loops_left;
  int cur[$];
  bit err_exp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_cur(input int a);
    cur.delete();
    while (a <= ml) begin
      cur.push_back(a);
      a += ms;
    end
  endtask

  // Called just after a negedge; returns just after the next negedge.
  task automatic do_start(input int b, input int l, input int s, input int rc);
    base = 8'(b); limit = 8'(l); step = 8'(s); repeat_cnt = 4'(rc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (b <= l) begin
      mb = b; ml = l; ms = (s == 0) ? 1 : s;
`ifdef SEQ_LOOP_EN
      loops_left = rc;
`else
      loops_left = 0;
`endif
      err_exp = 0;
      fill_cur(b);
    end else begin
      err_exp = 1;
      chk("bad_start_err", err, 1);
      chk("bad_start_valid", addr_valid, 0);
      chk("bad_start_busy", busy, 0);
    end
  endtask

  task automatic run_pass(input int rdy_pct, input int jump_at, input int jaddr,
                          input int stall_at, input bit rnd);
    int  xfers = 0;
    int  stalls = 0;
    bit  fin = 0;
    bit  ew = 0;
    bit  jumped = 0;
    bit  r, jv, in_win;
    int  ja;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      chk("valid", addr_valid, 1);
      chk("busy", busy, 1);
      chk("addr", addr_out, cur[0]);
      chk("wrapped", wrapped, ew);
      chk("done_low", done, 0);
      chk("err", err, err_exp);
      r = ($urandom_range(99) < rdy_pct);
      if (xfers == stall_at && stalls < 3) begin r = 0; stalls++; end
      jv = 0; ja = 0;
      if (!jumped && xfers == jump_at) begin jv = 1; ja = jaddr; jumped = 1; end
      else if (rnd && $urandom_range(31) == 0) begin jv = 1; ja = $urandom_range(255); end
      addr_ready = r; jump_valid = jv; jump_addr = 8'(ja);
      start = rnd && ($urandom_range(7) == 0);
      base = 8'($urandom_range(255)); limit = 8'($urandom_range(255));
      @(posedge clk);
      ew = 0;
      in_win = jv && (ja >= mb) && (ja <= ml);
      if (jv && !in_win) err_exp = 1;
      if (in_win) begin
        fill_cur(ja);
        if (r) xfers++;
      end else if (r) begin
        void'(cur.pop_front());
        xfers++;
        if (cur.size() == 0) begin
          if (loops_left > 0) begin
            loops_left--;
            fill_cur(mb);
            ew = 1;
          end else fin = 1;
        end
      end
      @(negedge clk);
    end
    addr_ready = 0; jump_valid = 0; start = 0;
    chk("pass_finished", fin, 1);
    chk("done_pulse", done, 1);
    chk("end_valid", addr_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_wrapped", wrapped, 0);
    chk("end_err", err, err_exp);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_valid", addr_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int b, l, s, rc;
    // Reset state
    #2;
    chk("rst_addr", addr_out, 0);
    chk("rst_valid", addr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic pass 4..16 step 3
    do_start(4, 16, 3, 0);
    run_pass(100, -1, 0, -1, 0);
    // Back-pressure on address 7 for three cycles
    do_start(4, 16, 3, 0);
    run_pass(100, -1, 0, 1, 0);
    // Carry out terminates the pass
    do_start(250, 255, 4, 0);
    run_pass(100, -1, 0, -1, 0);
    // Step 0 acts as 1
    do_start(0, 5, 0, 0);
    run_pass(100, -1, 0, -1, 0);
    // In-window jump at address 7
    do_start(4, 16, 3, 0);
    run_pass(100, 1, 12, -1, 0);
    // Out-of-window jump sets err
    do_start(4, 16, 3, 0);
    run_pass(100, 1, 20, -1, 0);
    // Bad window
    do_start(9, 3, 1, 0);
    @(negedge clk);
    chk("bad_start_stay_idle", addr_valid, 0);
    // Pass repetition
    do_start(0, 2, 1, 2);
    run_pass(100, -1, 0, -1, 0);

    // Asynchronous reset in the middle of a pass
    do_start(4, 16, 3, 0);
    chk("pre_rst_addr", addr_out, 4);
    addr_ready = 1'b1;
    @(negedge clk);
    addr_ready = 1'b0;
    chk("pre_rst_addr7", addr_out, 7);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_addr", addr_out, 0);
    chk("async_rst_valid", addr_valid, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", addr_valid, 0);
    err_exp = 0;
    do_start(4, 16, 3, 0);
    run_pass(100, -1, 0, -1, 0);

    // Randomised passes
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(9) == 0) begin
        b = $urandom_range(1, 255);
        l = $urandom_range(0, b - 1);
        do_start(b, l, 1, 0);
        @(negedge clk);
      end
      b  = $urandom_range(0, 255);
      l  = $urandom_range(b, 255);
      s  = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 40);
      rc = $urandom_range(0, 3);
      do_start(b, l, s, rc);
      run_pass(70, -1, 0, -1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/instr_addr_sequencer.md
Name: instr_addr_sequencer

Overview:
- Parametrised instruction-address generator for the matrix engine; successor to the fixed 3-bit offset counter.
- Walks an address window [base, limit] in programmable strides and presents each address to instruction memory over a valid/ready handshake.
- Adds start/done control, window wrap, jumps, error flagging and optional pass repetition.

Parameters:
- WIDTH, 8, address/step width in bits.
- LOOP_W, 4, width of repeat counter (used only with SEQ_LOOP_EN).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  begin a pass sequence; honoured only in IDLE.
- base  in  WIDTH  first address of window; sampled at start.
- limit  in  WIDTH  last legal address of window; sampled at start.
- step  in  WIDTH  stride; sampled at start; 0 treated as 1.
- jump_valid  in  1  load jump_addr as next address.
- jump_addr  in  WIDTH  jump target.
- repeat_cnt  in  LOOP_W  extra passes (SEQ_LOOP_EN only).
- addr_out  out  WIDTH  current address.
- addr_valid  out  1  addr_out is offered.
- addr_ready  in  1  consumer accepts addr_out.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at sequence end.
- wrapped  out  1  one-cycle pulse when a pass restarts at base.
- err  out  1  sticky error; cleared by the next accepted start.

Behaviour:
- Reset: all outputs 0. State IDLE. Internal registers (base/limit/step/loop count) 0.
- States:
  - IDLE: start=1 and base<=limit -> capture base/limit/step(/repeat_cnt); addr_out<=base; err<=0; RUN next cycle. start=1 with base>limit -> err<=1, stay IDLE.
  - RUN: addr_valid=1, busy=1.
    - Transfer = addr_valid & addr_ready.
    - On transfer, next = addr_out + step, computed WIDTH+1 bits wide.
    - If next <= limit and no carry out: addr_out<=next.
    - Else end of pass: go to DONE (or wrap, see feature).
  - DONE: addr_valid=0, busy=0, done=1 for exactly one cycle; IDLE next cycle.
- Handshake: addr_out must stay stable while addr_valid & !addr_ready, except on an accepted jump. No combinational path from addr_ready to addr_valid. Throughput is one address per cycle with addr_ready held high.
- Jump:
  - Sampled only in RUN.
  - jump_addr in [base, limit]: addr_out<=jump_addr next cycle, regardless of transfer. Jump wins over increment or end-of-pass on the same cycle.
  - jump_addr outside the window: jump ignored, err<=1, normal sequencing continues.
- start while busy: ignored, no error.
- Reset mid-operation: immediate return to reset values; pending address lost.
- Latency: start -> addr_valid = 1 cycle. Final transfer -> done = 1 cycle.

Optional Feature:
- Macro: SEQ_LOOP_EN.
- With: repeat_cnt port present; captured at start; total passes = repeat_cnt+1. At end of pass with loops remaining: addr_out<=base, wrapped pulse, loop count decremented, stay RUN without a bubble. Final pass -> DONE.
- Without: repeat_cnt port absent, single pass, wrapped tied 0.

Decomposition:
- Shared package matrix_engine_pkg holds:
  - seq_state_t enum (IDLE, RUN, DONE).
  - default WIDTH/LOOP_W constants.
  - sum-with-carry helper function.
- Natural sub-module: seq_stride_adder. Combinational add of WIDTH+1 bits, compare to limit, outputs next and overflow flag. Reused by future data-address generators.

Test Plan:
- base=4, limit=16, step=3, ready always high, start -> addresses 4,7,10,13,16; done pulses one cycle after the 16 transfer; busy low afterwards.
- Same setup, ready low for 3 cycles while addr_out=7 -> addr_out holds 7 and valid stays 1; resumes with 10.
- WIDTH=8, base=250, limit=255, step=4 -> 250,254, then carry-out terminates the pass; no wrap to 2.
- jump_valid with jump_addr=12 while addr_out=7 (window 4..16, step 3) -> next 12,15, done. jump_addr=20 -> ignored, err=1.
- SEQ_LOOP_EN, base=0, limit=2, step=1, repeat_cnt=2 -> 0,1,2,0,1,2,0,1,2; wrapped pulses twice; single done.
- Reset asserted mid-RUN at addr 7 -> outputs 0 asynchronously; start after release restarts at base. Additionally, start with base=9, limit=3 -> err=1, no addr_valid.
